wb_rep_sequencer: RTL

Writeback-stage controller that sequences REPNE CMPS string loops, and latches HALT. It tracks the two-uop CMPS pair as it retires through WB. After each second uop it either requests a replay of the pair from D2 or ends the loop, based on ZF and the decremented count. It sits beside the WB operand, validation and flag logic. It drives the replay, terminate and halt controls that the front end and the EIP load path consume.

---
 rtl/wb_pkg.sv | 18 +
 rtl/rep_iter_counter.sv | 35 +++
 rtl/wb_rep_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback REPNE CMPS sequencer.
// Also holds the ECX zero test used by the sequencer.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT2  = 2'b01,
    WAIT1  = 2'b10,
    HALTED = 2'b11
  } rep_state_e;

  localparam int ZF_BIT = 6;

  function automatic logic equal_to_zero(input logic [31:0] value);
    return (value == 32'd0);
  endfunction

endpackage

// File: rtl/rep_iter_counter.sv
// Saturating iteration counter with synchronous clear and count enable.
// Clear wins over enable; the count holds once it reaches all-ones.
module rep_iter_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_rep_sequencer.sv
// Writeback controller for REPNE CMPS loops: replays the uop pair, ends the
// loop on ZF or ECX exhaustion, and latches HALT until reset.
module wb_rep_sequencer
  import wb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             WB_V,
  input  logic             wb_stall,
  input  logic             CS_IS_CMPS_FIRST_UOP_ALL,
  input  logic             CS_IS_CMPS_SECOND_UOP_ALL,
  input  logic             WB_d2_repne_wb,
  input  logic             CS_IS_HALT_WB,
  input  logic [31:0]      current_flags,
  input  logic [31:0]      WB_RESULT_C,
  output logic             rep_active,
  output logic             rep_replay,
  output logic             wb_repne_terminate_all,
  output logic             rep_skip,
  output logic             rep_err,
  output logic             wb_halt_all,
  output logic [CNT_W-1:0] rep_iter,
  output logic [1:0]       dbg_state
);

  rep_state_e state_q, state_d;
  logic replay_q, replay_d;
  logic term_q, term_d;
  logic skip_q, skip_d;
  logic err_q, err_d;
  logic halt_q, halt_d;
  logic cnt_clr, cnt_en;
  logic retire;
  logic zf;
  logic ecx_zero;
  logic unused_flags;

  // Handshake: a uop retires only on a cycle with WB_V=1 and wb_stall=0.
  // Any other cycle is a hold: no state change, no counter change, no pulse.
  assign retire       = WB_V && !wb_stall;
  assign zf           = current_flags[ZF_BIT];
  assign ecx_zero     = equal_to_zero(WB_RESULT_C);
  assign unused_flags = ^{current_flags[31:ZF_BIT+1], current_flags[ZF_BIT-1:0]};

  always_comb begin
    state_d  = state_q;
    replay_d = 1'b0;
    term_d   = 1'b0;
    skip_d   = 1'b0;
    err_d    = 1'b0;
    halt_d   = halt_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (retire) begin
      if (CS_IS_HALT_WB) begin
        state_d = HALTED;
        halt_d  = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (CS_IS_CMPS_FIRST_UOP_ALL && WB_d2_repne_wb) begin
              if (ecx_zero) begin
                skip_d = 1'b1;
              end else begin
                cnt_clr = 1'b1;
                state_d = WAIT2;
              end
            end
          end
          WAIT2: begin
            if (CS_IS_CMPS_SECOND_UOP_ALL) begin
              cnt_en = 1'b1;
              if (zf || ecx_zero) begin
                term_d  = 1'b1;
                state_d = IDLE;
              end else begin
                replay_d = 1'b1;
                state_d  = WAIT1;
              end
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          WAIT1: begin
            // The replayed first uop carries the same count; no recheck here.
            if (CS_IS_CMPS_FIRST_UOP_ALL) begin
              state_d = WAIT2;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          HALTED: begin
            state_d = HALTED;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q  <= IDLE;
      replay_q <= 1'b0;
      term_q   <= 1'b0;
      skip_q   <= 1'b0;
      err_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      replay_q <= replay_d;
      term_q   <= term_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
      halt_q   <= halt_d;
    end
  end

  rep_iter_counter #(
    .W(CNT_W)
  ) u_iter (
    .clk_i  (CLK),
    .rst_n_i(CLR),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (rep_iter)
  );

  assign rep_active             = (state_q == WAIT1) || (state_q == WAIT2);
  assign rep_replay             = replay_q;
  assign wb_repne_terminate_all = term_q;
  assign rep_skip               = skip_q;
  assign rep_err                = err_q;
  assign wb_halt_all            = halt_q;
  assign dbg_state              = state_q;

endmodule
